// File: rtl/mem_access.sv
// mem_access: single-outstanding bus master for the MEM stage with a
// one-deep pending buffer.
//
// Requests are sampled from EX_MEM* on every clock edge. A request is legal
// when exactly one of rden/wren is nonzero and the address is word aligned.
// Illegal requests are dropped and flagged on MEM_err. Requests that arrive
// while both the active slot and the pending buffer are full are also dropped
// and flagged. The active request is held on bus_* until bus_ack, or until
// TIMEOUT wait cycles pass, in which case it is aborted and flagged.
//
// Ports
//   clk, rst          clock, async active-high reset
//   EX_MEMaddr/rden/wren/wrdata   request inputs
//   bus_req/we/addr/be/wdata      active bus request (all registered)
//   bus_ack, bus_rdata            completion and read data
//   MEM_x_rd_vld, MEM_x_rd        load result strobe and held value
//   MEM_busy                      active slot occupied
//   MEM_err                       one-cycle error strobe
module mem_access #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] EX_MEMaddr,
  input  logic [3:0]  EX_MEMrden,
  input  logic [3:0]  EX_MEMwren,
  input  logic [31:0] EX_MEMwrdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        MEM_x_rd_vld,
  output logic [31:0] MEM_x_rd,
  output logic        MEM_busy,
  output logic        MEM_err
);

  localparam logic [7:0] TO = 8'(TIMEOUT);

  typedef enum logic {IDLE, BUS} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } req_t;

  state_t      state_q, state_d;
  req_t        act_q, act_d, pend_q, pend_d, new_req;
  logic        pend_vld_q, pend_vld_d;
  logic [7:0]  wait_q, wait_d;
  logic        rd_vld_q, rd_vld_d;
  logic [31:0] rd_q, rd_d;
  logic        err_q, err_d;

  logic rd_nz, wr_nz, aligned, req_ok, req_bad, timeout_hit, done;

  always_comb begin
    rd_nz   = |EX_MEMrden;
    wr_nz   = |EX_MEMwren;
    aligned = (EX_MEMaddr[1:0] == 2'b00);
    req_ok  = (rd_nz ^ wr_nz) & aligned;
    req_bad = (rd_nz & wr_nz) | ((rd_nz | wr_nz) & ~aligned);

    new_req.addr  = EX_MEMaddr;
    new_req.be    = wr_nz ? EX_MEMwren : EX_MEMrden;
    new_req.we    = wr_nz;
    new_req.wdata = wr_nz ? EX_MEMwrdata : 32'h0;

    // ack wins over timeout when both land on the same edge
    timeout_hit = ~bus_ack && ((wait_q + 8'd1) == TO);
    done        = (state_q == BUS) && (bus_ack || timeout_hit);

    state_d    = state_q;
    act_d      = act_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    wait_d     = wait_q;
    rd_vld_d   = 1'b0;
    rd_d       = rd_q;
    err_d      = req_bad;

    case (state_q)
      IDLE: begin
        if (req_ok) begin
          state_d = BUS;
          act_d   = new_req;
          wait_d  = 8'd0;
        end
      end
      BUS: begin
        if (done) begin
          if (bus_ack && !act_q.we) begin
            rd_vld_d = 1'b1;
            for (int i = 0; i < 4; i++)
              rd_d[8*i +: 8] = act_q.be[i] ? bus_rdata[8*i +: 8] : 8'h00;
          end
          if (timeout_hit) err_d = 1'b1;
          wait_d = 8'd0;
          // pending is older than the same-edge request, so it goes first
          if (pend_vld_q) begin
            act_d      = pend_q;
            pend_vld_d = req_ok;
            if (req_ok) pend_d = new_req;
          end else if (req_ok) begin
            act_d = new_req;
          end else begin
            state_d = IDLE;
          end
        end else begin
          wait_d = wait_q + 8'd1;
          if (req_ok) begin
            if (pend_vld_q) begin
              err_d = 1'b1;
            end else begin
              pend_d     = new_req;
              pend_vld_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      act_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      wait_q     <= 8'd0;
      rd_vld_q   <= 1'b0;
      rd_q       <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      act_q      <= act_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      wait_q     <= wait_d;
      rd_vld_q   <= rd_vld_d;
      rd_q       <= rd_d;
      err_q      <= err_d;
    end
  end

  assign bus_req      = (state_q == BUS);
  assign MEM_busy     = (state_q == BUS);
  assign bus_we       = act_q.we;
  assign bus_addr     = act_q.addr;
  assign bus_be       = act_q.be;
  assign bus_wdata    = act_q.wdata;
  assign MEM_x_rd_vld = rd_vld_q;
  assign MEM_x_rd     = rd_q;
  assign MEM_err      = err_q;

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

  logic        clk, rst;
  logic [31:0] EX_MEMaddr, EX_MEMwrdata, bus_addr, bus_wdata, bus_rdata, MEM_x_rd;
  logic [3:0]  EX_MEMrden, EX_MEMwren, bus_be;
  logic        bus_req, bus_we, bus_ack, MEM_x_rd_vld, MEM_busy, MEM_err;

  mem_access #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .EX_MEMaddr(EX_MEMaddr), .EX_MEMrden(EX_MEMrden), .EX_MEMwren(EX_MEMwren),
    .EX_MEMwrdata(EX_MEMwrdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .MEM_x_rd_vld(MEM_x_rd_vld), .MEM_x_rd(MEM_x_rd), .MEM_busy(MEM_busy),
    .MEM_err(MEM_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int vld_cnt = 0;
  int err_cnt = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: every load strobe must match the oldest expected read
  always @(negedge clk) begin
    if (MEM_err === 1'b1) err_cnt++;
    if (MEM_x_rd_vld === 1'b1) begin
      vld_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rd_strobe: got unexpected strobe data %h expected none", MEM_x_rd);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (MEM_x_rd !== e) begin
          failures++;
          $display("FAIL rd_data: got %h expected %h", MEM_x_rd, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    EX_MEMrden = 4'h0; EX_MEMwren = 4'h0; EX_MEMaddr = 32'h0; EX_MEMwrdata = 32'h0;
  endtask

  task automatic put(input logic [31:0] a, input logic [3:0] rd, input logic [3:0] wr,
                     input logic [31:0] wd);
    EX_MEMaddr = a; EX_MEMrden = rd; EX_MEMwren = wr; EX_MEMwrdata = wd;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  rden;
    logic [3:0]  wren;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_cyc;
    logic        exp_req;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [31:0] last_rd;
    int v0, e0;

    vecs[0] = '{32'h100, 4'hF, 4'h0, 32'h0,        32'hDEADBEEF, 3, 1'b1, 1'b0, 32'hDEADBEEF};
    vecs[1] = '{32'h200, 4'h0, 4'hF, 32'h12345678, 32'hFFFFFFFF, 2, 1'b1, 1'b0, 32'h0};
    vecs[2] = '{32'h104, 4'h5, 4'h0, 32'h0,        32'hDEADBEEF, 1, 1'b1, 1'b0, 32'h00AD00EF};
    vecs[3] = '{32'h108, 4'hC, 4'h0, 32'h0,        32'hCAFEF00D, 4, 1'b1, 1'b0, 32'hCAFE0000};
    vecs[4] = '{32'h102, 4'hF, 4'h0, 32'h0,        32'h0,        0, 1'b0, 1'b1, 32'h0};
    vecs[5] = '{32'h300, 4'hF, 4'hF, 32'h0,        32'h0,        0, 1'b0, 1'b1, 32'h0};
    vecs[6] = '{32'h010, 4'h0, 4'h3, 32'hA5A5A5A5, 32'h0,        1, 1'b1, 1'b0, 32'h0};
    vecs[7] = '{32'h103, 4'h0, 4'h0, 32'h0,        32'h0,        0, 1'b0, 1'b0, 32'h0};

    rst = 1'b1; bus_ack = 1'b0; bus_rdata = 32'h0; idle_in();
    tick();
    chk("reset_req",   {31'b0, bus_req}, 32'h0);
    chk("reset_busy",  {31'b0, MEM_busy}, 32'h0);
    chk("reset_addr",  bus_addr, 32'h0);
    chk("reset_rd",    MEM_x_rd, 32'h0);
    chk("reset_flags", {28'b0, bus_we, MEM_x_rd_vld, MEM_err, 1'b0}, 32'h0);
    rst = 1'b0;
    tick();
    last_rd = 32'h0;

    // ---------------- table-driven single transactions ----------------
    foreach (vecs[n]) begin
      v0 = vld_cnt;
      put(vecs[n].addr, vecs[n].rden, vecs[n].wren, vecs[n].wdata);
      tick();
      idle_in();
      chk($sformatf("v%0d_req", n), {31'b0, bus_req}, {31'b0, vecs[n].exp_req});
      chk($sformatf("v%0d_err", n), {31'b0, MEM_err}, {31'b0, vecs[n].exp_err});
      if (vecs[n].exp_req) begin
        if (vecs[n].wren == 4'h0) exp_q.push_back(vecs[n].exp_rd);
        for (int c = 1; c <= vecs[n].ack_cyc; c++) begin
          chk($sformatf("v%0d_hold_req", n), {31'b0, bus_req}, 32'h1);
          chk($sformatf("v%0d_addr", n), bus_addr, vecs[n].addr);
          chk($sformatf("v%0d_we", n), {31'b0, bus_we}, {31'b0, vecs[n].wren != 4'h0});
          if (vecs[n].wren != 4'h0) begin
            chk($sformatf("v%0d_wdata", n), bus_wdata, vecs[n].wdata);
            chk($sformatf("v%0d_be", n), {28'b0, bus_be}, {28'b0, vecs[n].wren});
          end else begin
            chk($sformatf("v%0d_be", n), {28'b0, bus_be}, {28'b0, vecs[n].rden});
          end
          if (c == vecs[n].ack_cyc) begin
            bus_ack = 1'b1; bus_rdata = vecs[n].rdata;
          end
          tick();
        end
        bus_ack = 1'b0;
        chk($sformatf("v%0d_done_req", n), {31'b0, bus_req}, 32'h0);
        chk($sformatf("v%0d_vld", n), {31'b0, MEM_x_rd_vld}, {31'b0, vecs[n].wren == 4'h0});
        chk($sformatf("v%0d_noerr", n), {31'b0, MEM_err}, 32'h0);
        if (vecs[n].wren == 4'h0) last_rd = vecs[n].exp_rd;
      end
      tick();
      chk($sformatf("v%0d_strobe_once", n), {31'b0, MEM_x_rd_vld}, 32'h0);
      chk($sformatf("v%0d_err_once", n), {31'b0, MEM_err}, 32'h0);
      chk($sformatf("v%0d_rd_hold", n), MEM_x_rd, last_rd);
      chk($sformatf("v%0d_strobes", n), vld_cnt - v0,
          (vecs[n].exp_req && vecs[n].wren == 4'h0) ? 32'd1 : 32'd0);
    end

    // ---------------- back-to-back: third request dropped ----------------
    v0 = vld_cnt; e0 = err_cnt;
    put(32'h400, 4'hF, 4'h0, 32'h0); tick();
    chk("b2b_req1", {31'b0, bus_req}, 32'h1);
    put(32'h404, 4'hF, 4'h0, 32'h0); tick();
    chk("b2b_req2", {31'b0, bus_req}, 32'h1);
    put(32'h408, 4'hF, 4'h0, 32'h0); tick();
    idle_in();
    exp_q.push_back(32'h11111111);
    exp_q.push_back(32'h22222222);
    chk("b2b_drop_err", {31'b0, MEM_err}, 32'h1);
    chk("b2b_addr0", bus_addr, 32'h400);
    bus_ack = 1'b1; bus_rdata = 32'h11111111; tick();
    bus_ack = 1'b0;
    chk("b2b_req_cont", {31'b0, bus_req}, 32'h1);
    chk("b2b_addr1", bus_addr, 32'h404);
    tick();
    chk("b2b_req_wait", {31'b0, bus_req}, 32'h1);
    bus_ack = 1'b1; bus_rdata = 32'h22222222; tick();
    bus_ack = 1'b0;
    chk("b2b_idle", {31'b0, bus_req}, 32'h0);
    tick(); tick();
    chk("b2b_strobes", vld_cnt - v0, 32'd2);
    chk("b2b_errs", err_cnt - e0, 32'd1);

    // ---------------- completion with a same-edge new request ----------------
    v0 = vld_cnt;
    put(32'h500, 4'hF, 4'h0, 32'h0); tick();
    exp_q.push_back(32'h55667788);
    put(32'h504, 4'h0, 4'hF, 32'h0BADF00D);
    bus_ack = 1'b1; bus_rdata = 32'h55667788; tick();
    bus_ack = 1'b0; idle_in();
    chk("direct_req", {31'b0, bus_req}, 32'h1);
    chk("direct_addr", bus_addr, 32'h504);
    chk("direct_we", {31'b0, bus_we}, 32'h1);
    chk("direct_wdata", bus_wdata, 32'h0BADF00D);
    bus_ack = 1'b1; tick();
    bus_ack = 1'b0;
    chk("direct_idle", {31'b0, bus_req}, 32'h0);
    tick();
    chk("direct_strobes", vld_cnt - v0, 32'd1);

    // ---------------- pending full at completion: nothing dropped ----------------
    v0 = vld_cnt; e0 = err_cnt;
    put(32'h800, 4'hF, 4'h0, 32'h0); tick();
    put(32'h804, 4'hF, 4'h0, 32'h0); tick();
    put(32'h808, 4'hF, 4'h0, 32'h0);
    exp_q.push_back(32'hAAAA0001);
    exp_q.push_back(32'hAAAA0002);
    exp_q.push_back(32'hAAAA0003);
    bus_ack = 1'b1; bus_rdata = 32'hAAAA0001; tick();
    idle_in();
    chk("pfull_addr_y", bus_addr, 32'h804);
    chk("pfull_noerr", {31'b0, MEM_err}, 32'h0);
    bus_rdata = 32'hAAAA0002; tick();
    chk("pfull_addr_z", bus_addr, 32'h808);
    chk("pfull_req_z", {31'b0, bus_req}, 32'h1);
    bus_rdata = 32'hAAAA0003; tick();
    bus_ack = 1'b0;
    chk("pfull_idle", {31'b0, bus_req}, 32'h0);
    tick();
    chk("pfull_strobes", vld_cnt - v0, 32'd3);
    chk("pfull_errs", err_cnt - e0, 32'd0);

    // ---------------- timeout after four wait cycles ----------------
    v0 = vld_cnt; e0 = err_cnt;
    put(32'h600, 4'hF, 4'h0, 32'h0); tick();
    idle_in();
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("to_req_c%0d", c), {31'b0, bus_req}, 32'h1);
      tick();
    end
    chk("to_req_fall", {31'b0, bus_req}, 32'h0);
    chk("to_err", {31'b0, MEM_err}, 32'h1);
    tick();
    chk("to_err_once", {31'b0, MEM_err}, 32'h0);
    chk("to_strobes", vld_cnt - v0, 32'd0);
    chk("to_errs", err_cnt - e0, 32'd1);

    // ---------------- reset mid-operation with pending full ----------------
    v0 = vld_cnt; e0 = err_cnt;
    put(32'h700, 4'hF, 4'h0, 32'h0); tick();
    put(32'h704, 4'hF, 4'h0, 32'h0); tick();
    idle_in();
    chk("rst_pre_req", {31'b0, bus_req}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("rst_req", {31'b0, bus_req}, 32'h0);
    chk("rst_busy", {31'b0, MEM_busy}, 32'h0);
    chk("rst_fields", bus_addr | bus_wdata | {27'b0, bus_be, bus_we}, 32'h0);
    chk("rst_rd", MEM_x_rd, 32'h0);
    tick();
    rst = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'h77777777; tick();
    bus_ack = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    chk("rst_after_req", {31'b0, bus_req}, 32'h0);
    chk("rst_no_strobe", vld_cnt - v0, 32'd0);
    chk("rst_no_err", err_cnt - e0, 32'd0);
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
